// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// thresholds, overflow/underflow pulses and registered or first-word-fall-through read.
module fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 32,
    parameter int AF_MARGIN = 4,
    parameter int AE_MARGIN = 4,
    parameter int FWFT      = 0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       WR_EN,
    input  logic                       RD_EN,
    input  logic [DATA_W-1:0]          DATA_IN,
    output logic [DATA_W-1:0]          DATA_OUT,
    output logic [$clog2(DEPTH):0]     COUNT,
    output logic                       EF,
    output logic                       AEF,
    output logic                       FF,
    output logic                       AFF,
    output logic                       VF,
    output logic                       OF,
    output logic                       UF
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - AF_MARGIN);
    localparam logic [CW-1:0] AE_LVL   = CW'(AE_MARGIN);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;
    logic [DATA_W-1:0] data_q;
    logic              vf_q;
    logic              of_q;
    logic              uf_q;
    logic              rd_ok;
    logic              wr_ok;

    // A read frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
    always_comb begin
        rd_ok = RD_EN && (count_q != '0);
        wr_ok = WR_EN && ((count_q != FULL_LVL) || rd_ok);
    end

    always_ff @(posedge CLK) begin
        if (!RST && wr_ok) begin
            mem[wr_ptr] <= DATA_IN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            data_q  <= '0;
            vf_q    <= 1'b0;
            of_q    <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
                data_q <= mem[rd_ptr];
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            vf_q <= rd_ok;
            of_q <= WR_EN && !wr_ok;
            uf_q <= RD_EN && !rd_ok;
        end
    end

    always_comb begin
        COUNT = count_q;
        EF    = (count_q == '0);
        AEF   = (count_q <= AE_LVL);
        FF    = (count_q == FULL_LVL);
        AFF   = (count_q >= AF_LVL);
        OF    = of_q;
        UF    = uf_q;
    end

    // In fall-through mode an empty FIFO keeps showing the last popped word rather than stale memory.
    always_comb begin
        if (FWFT != 0) begin
            VF       = !EF;
            DATA_OUT = EF ? data_q : mem[rd_ptr];
        end else begin
            VF       = vf_q;
            DATA_OUT = data_q;
        end
    end

endmodule

// File: tb/tb_fifo_param.sv
// Scoreboard bench for fifo_param: registered and fall-through instances share one stimulus stream.
module tb_fifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 32;
    localparam int CW    = 6;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          WR_EN = 1'b0;
    logic          RD_EN = 1'b0;
    logic [DW-1:0] DATA_IN = '0;

    logic [DW-1:0] dout0, dout1;
    logic [CW-1:0] cnt0, cnt1;
    logic ef0, aef0, ff0, aff0, vf0, of0, uf0;
    logic ef1, aef1, ff1, aff1, vf1, of1, uf1;

    fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_MARGIN(4), .AE_MARGIN(4), .FWFT(0)) u_reg (
        .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .RD_EN(RD_EN), .DATA_IN(DATA_IN),
        .DATA_OUT(dout0), .COUNT(cnt0), .EF(ef0), .AEF(aef0), .FF(ff0), .AFF(aff0),
        .VF(vf0), .OF(of0), .UF(uf0)
    );

    fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_MARGIN(4), .AE_MARGIN(4), .FWFT(1)) u_fwft (
        .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .RD_EN(RD_EN), .DATA_IN(DATA_IN),
        .DATA_OUT(dout1), .COUNT(cnt1), .EF(ef1), .AEF(aef1), .FF(ff1), .AFF(aff1),
        .VF(vf1), .OF(of1), .UF(uf1)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int fails  = 0;

    logic [DW-1:0] sb[$];
    logic [DW-1:0] exp_dout = '0;
    bit            exp_vf0  = 1'b0;

    // Drives one cycle of stimulus and advances the reference queue; samples land #1 after the edge.
    task automatic step(input bit wr, input bit rd, input logic [DW-1:0] d);
        bit rd_ok;
        bit wr_ok;
        rd_ok = rd && (sb.size() != 0);
        wr_ok = wr && ((sb.size() != DEPTH) || rd_ok);
        WR_EN   = wr;
        RD_EN   = rd;
        DATA_IN = d;
        exp_vf0 = rd_ok;
        if (rd_ok) exp_dout = sb.pop_front();
        if (wr_ok) sb.push_back(d);
        @(posedge CLK);
        #1;
        WR_EN = 1'b0;
        RD_EN = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        WR_EN = 1'b0;
        RD_EN = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        sb.delete();
        exp_dout = '0;
        checks++;
        if ({cnt0, ef0, aef0, ff0, aff0, vf0, of0, uf0, dout0} !== {6'd0, 7'b1100000, 8'd0}) begin
            fails++;
            $display("FAIL reset_reg: got cnt=%0d ef/aef/ff/aff/vf/of/uf=%b%b%b%b%b%b%b dout=%0d expected cnt=0 flags=1100000 dout=0",
                     cnt0, ef0, aef0, ff0, aff0, vf0, of0, uf0, dout0);
        end
        checks++;
        if ({cnt1, ef1, aef1, ff1, aff1, vf1, of1, uf1, dout1} !== {6'd0, 7'b1100000, 8'd0}) begin
            fails++;
            $display("FAIL reset_fwft: got cnt=%0d ef/aef/ff/aff/vf/of/uf=%b%b%b%b%b%b%b dout=%0d expected cnt=0 flags=1100000 dout=0",
                     cnt1, ef1, aef1, ff1, aff1, vf1, of1, uf1, dout1);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, 1'b0, DW'(i));
            checks++;
            if (cnt0 !== CW'(i)) begin
                fails++;
                $display("FAIL fill_count: got %0d expected %0d", cnt0, i);
            end
            checks++;
            if ({ef0, aef0, ff0, aff0, of0} !== {1'b0, 1'(i <= 4), 1'(i == DEPTH), 1'(i >= 28), 1'b0}) begin
                fails++;
                $display("FAIL fill_flags at count %0d: got ef/aef/ff/aff/of=%b%b%b%b%b expected 0%b%b%b0",
                         i, ef0, aef0, ff0, aff0, of0, 1'(i <= 4), 1'(i == DEPTH), 1'(i >= 28));
            end
        end
        step(1'b1, 1'b0, 8'd33);
        checks++;
        if (of0 !== 1'b1 || of1 !== 1'b1) begin
            fails++;
            $display("FAIL overflow_pulse: got of=%b/%b expected 1/1", of0, of1);
        end
        checks++;
        if (cnt0 !== 6'd32 || cnt1 !== 6'd32) begin
            fails++;
            $display("FAIL overflow_count: got %0d/%0d expected 32", cnt0, cnt1);
        end
        step(1'b0, 1'b0, '0);
        checks++;
        if (of0 !== 1'b0) begin
            fails++;
            $display("FAIL overflow_width: got of=%b expected 0", of0);
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= DEPTH; i++) begin
            checks++;
            if (dout1 !== DW'(i) || vf1 !== 1'b1) begin
                fails++;
                $display("FAIL drain_fwft_head %0d: got data=%0d vf=%b expected data=%0d vf=1", i, dout1, vf1, i);
            end
            step(1'b0, 1'b1, '0);
            checks++;
            if (dout0 !== exp_dout || vf0 !== 1'b1 || exp_dout !== DW'(i)) begin
                fails++;
                $display("FAIL drain_reg_data %0d: got data=%0d vf=%b expected data=%0d vf=1", i, dout0, vf0, i);
            end
            checks++;
            if (cnt0 !== CW'(DEPTH - i) || ef0 !== 1'(i == DEPTH)) begin
                fails++;
                $display("FAIL drain_count %0d: got cnt=%0d ef=%b expected cnt=%0d ef=%b", i, cnt0, ef0, DEPTH - i, 1'(i == DEPTH));
            end
        end
        step(1'b0, 1'b1, '0);
        checks++;
        if (uf0 !== 1'b1 || uf1 !== 1'b1) begin
            fails++;
            $display("FAIL underflow_pulse: got uf=%b/%b expected 1/1", uf0, uf1);
        end
        checks++;
        if (dout0 !== 8'd32 || dout1 !== 8'd32 || vf0 !== 1'b0 || vf1 !== 1'b0 || cnt0 !== 6'd0) begin
            fails++;
            $display("FAIL underflow_hold: got data=%0d/%0d vf=%b/%b cnt=%0d expected data=32/32 vf=0/0 cnt=0",
                     dout0, dout1, vf0, vf1, cnt0);
        end
        step(1'b0, 1'b0, '0);
        checks++;
        if (uf0 !== 1'b0 || vf0 !== 1'b0) begin
            fails++;
            $display("FAIL underflow_width: got uf=%b vf=%b expected 0 0", uf0, vf0);
        end
    endtask

    task automatic test_wrap();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 20; i++) step(1'b1, 1'b0, DW'(100 + r * 20 + i));
            for (int i = 0; i < 20; i++) begin
                checks++;
                if (dout1 !== sb[0]) begin
                    fails++;
                    $display("FAIL wrap_fwft r%0d i%0d: got %0d expected %0d", r, i, dout1, sb[0]);
                end
                step(1'b0, 1'b1, '0);
                checks++;
                if (dout0 !== exp_dout || vf0 !== exp_vf0 || exp_dout !== DW'(100 + r * 20 + i)) begin
                    fails++;
                    $display("FAIL wrap_reg r%0d i%0d: got data=%0d vf=%b expected data=%0d vf=1",
                             r, i, dout0, vf0, 100 + r * 20 + i);
                end
            end
            checks++;
            if (cnt0 !== 6'd0 || ef0 !== 1'b1) begin
                fails++;
                $display("FAIL wrap_empty r%0d: got cnt=%0d ef=%b expected 0 1", r, cnt0, ef0);
            end
        end
    endtask

    task automatic test_full_rw();
        logic [DW-1:0] e;
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, DW'(i));
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, DW'(40 + k));
            checks++;
            if (of0 !== 1'b0 || cnt0 !== 6'd32 || ff0 !== 1'b1) begin
                fails++;
                $display("FAIL full_rw_state %0d: got of=%b cnt=%0d ff=%b expected 0 32 1", k, of0, cnt0, ff0);
            end
            checks++;
            if (dout0 !== DW'(k + 1)) begin
                fails++;
                $display("FAIL full_rw_data %0d: got %0d expected %0d", k, dout0, k + 1);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            e = (i < 27) ? DW'(6 + i) : DW'(40 + i - 27);
            checks++;
            if (dout1 !== e) begin
                fails++;
                $display("FAIL full_rw_drain_fwft %0d: got %0d expected %0d", i, dout1, e);
            end
            step(1'b0, 1'b1, '0);
            checks++;
            if (dout0 !== e || dout0 !== exp_dout) begin
                fails++;
                $display("FAIL full_rw_drain_reg %0d: got %0d expected %0d", i, dout0, e);
            end
        end
    endtask

    task automatic test_empty_rw();
        step(1'b1, 1'b1, 8'd77);
        checks++;
        if (uf0 !== 1'b1 || of0 !== 1'b0 || cnt0 !== 6'd1) begin
            fails++;
            $display("FAIL empty_rw: got uf=%b of=%b cnt=%0d expected 1 0 1", uf0, of0, cnt0);
        end
        checks++;
        if (dout0 !== exp_dout || vf0 !== 1'b0) begin
            fails++;
            $display("FAIL empty_rw_hold: got data=%0d vf=%b expected data=%0d vf=0", dout0, vf0, exp_dout);
        end
        step(1'b0, 1'b0, '0);
        checks++;
        if (uf0 !== 1'b0 || dout1 !== 8'd77 || vf1 !== 1'b1) begin
            fails++;
            $display("FAIL empty_rw_fwft: got uf=%b data=%0d vf=%b expected 0 77 1", uf0, dout1, vf1);
        end
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, DW'(i + 1));
        checks++;
        if (cnt0 !== 6'd10 || aef0 !== 1'b0) begin
            fails++;
            $display("FAIL pre_reset_count: got cnt=%0d aef=%b expected 10 0", cnt0, aef0);
        end
        RST = 1'b1;
        WR_EN = 1'b1;
        RD_EN = 1'b1;
        DATA_IN = 8'd5;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        WR_EN = 1'b0;
        RD_EN = 1'b0;
        sb.delete();
        exp_dout = '0;
        checks++;
        if ({cnt0, ef0, aef0, ff0, aff0, vf0, of0, uf0, dout0} !== {6'd0, 7'b1100000, 8'd0}) begin
            fails++;
            $display("FAIL mid_reset_reg: got cnt=%0d flags=%b%b%b%b%b%b%b dout=%0d expected cnt=0 flags=1100000 dout=0",
                     cnt0, ef0, aef0, ff0, aff0, vf0, of0, uf0, dout0);
        end
        checks++;
        if ({cnt1, ef1, aef1, ff1, aff1, vf1, of1, uf1, dout1} !== {6'd0, 7'b1100000, 8'd0}) begin
            fails++;
            $display("FAIL mid_reset_fwft: got cnt=%0d flags=%b%b%b%b%b%b%b dout=%0d expected cnt=0 flags=1100000 dout=0",
                     cnt1, ef1, aef1, ff1, aff1, vf1, of1, uf1, dout1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_full_rw();
        test_empty_rw();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
